// File: rtl/mips_alu_pkg.sv
// ----------------------------------------------------------------------------
// mips_alu_pkg
// Shared definitions for the MIPS-style ALU with iterative multiply/divide.
//   alu_op_e   : 5-bit opcode encoding driven on mips_muldiv_alu.alu_op
//   state_e    : sequencing FSM states (ST_DIV exists only when
//                MIPS_MULDIV_ALU_DIV_EN is defined)
//   is_mul_op  : true for MULT/MULTU
//   is_div_op  : true for DIV/DIVU
// Configuration macro: MIPS_MULDIV_ALU_DIV_EN (enables the divider).
// ----------------------------------------------------------------------------
package mips_alu_pkg;

    typedef enum logic [4:0] {
        OP_AND   = 5'h00,
        OP_OR    = 5'h01,
        OP_NOR   = 5'h02,
        OP_XOR   = 5'h03,
        OP_ADD   = 5'h04,
        OP_ADDU  = 5'h05,
        OP_SUB   = 5'h06,
        OP_SUBU  = 5'h07,
        OP_SLL   = 5'h08,
        OP_SRL   = 5'h09,
        OP_SRA   = 5'h0A,
        OP_LUI   = 5'h0B,
        OP_SLT   = 5'h0C,
        OP_SLTU  = 5'h0D,
        OP_MULT  = 5'h10,
        OP_MULTU = 5'h11,
        OP_DIV   = 5'h12,
        OP_DIVU  = 5'h13,
        OP_MFHI  = 5'h14,
        OP_MFLO  = 5'h15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef MIPS_MULDIV_ALU_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_MUL  = 2'd1
    } state_e;

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mips_div_iter.sv
// ----------------------------------------------------------------------------
// mips_div_iter
// Restoring divider, one quotient bit per clock. Only instantiated when
// MIPS_MULDIV_ALU_DIV_EN is defined.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : load operands (one-cycle pulse)
//   is_signed           : treat operands as two's complement
//   dividend, divisor   : operands sampled on start
//   done                : high for the cycle in which quotient/remainder
//                         are final (WIDTH edges after start)
//   quotient, remainder : sign-corrected results, valid while done
// Signed results truncate toward zero; the remainder takes the dividend's
// sign. Divide-by-zero yields an all-ones quotient and remainder = dividend.
// ----------------------------------------------------------------------------
module mips_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic             quo_neg;
    logic             rem_neg;
    logic             dvs_zero;

    logic             dend_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dend_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // The iteration works on magnitudes; signs are reapplied at the end.
    // The partial remainder is always below the divisor, so the shifted
    // value fits in WIDTH+1 bits and bit WIDTH of the trial is the borrow.
    always_comb begin
        dend_neg = is_signed && dividend[WIDTH-1];
        dvs_neg  = is_signed && divisor[WIDTH-1];
        dend_mag = dend_neg ? -dividend : dividend;
        dvs_mag  = dvs_neg  ? -divisor  : divisor;
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, dvs};
    end

    // Iteration registers: the dividend magnitude shifts out of quo while
    // quotient bits shift in behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            dvs_zero <= 1'b0;
        end else if (start) begin
            active   <= 1'b1;
            cnt      <= '0;
            quo      <= dend_mag;
            rem      <= '0;
            dvs      <= dvs_mag;
            quo_neg  <= dend_neg ^ dvs_neg;
            rem_neg  <= dend_neg;
            dvs_zero <= (divisor == '0);
        end else if (active) begin
            if (cnt != CNT_LAST) begin
                if (!trial[WIDTH]) begin
                    rem <= trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
                cnt <= cnt + CNT_W'(1);
            end else begin
                active <= 1'b0;
            end
        end
    end

    assign done      = active && (cnt == CNT_LAST);
    assign quotient  = dvs_zero ? '1 : (quo_neg ? -quo : quo);
    assign remainder = rem_neg ? -rem : rem;

endmodule

// File: rtl/mips_muldiv_alu.sv
// ----------------------------------------------------------------------------
// mips_muldiv_alu
// MIPS-style integer ALU: single-cycle logic/arith/shift/compare ops plus an
// iterative radix-2 multiplier and (optionally) a restoring divider that
// write the HI/LO register pair.
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid / in_ready       : operation handshake (accept when both high)
//   alu_op                    : opcode (mips_alu_pkg::alu_op_e encoding)
//   first_data, second_data   : operands A and B
//   shamt                     : shift amount for SLL/SRL/SRA
//   out_valid, result,
//   zero, ovf                 : registered result bundle (one-cycle pulse)
//   hi, lo                    : multiply/divide result registers
//   busy                      : iterative operation in progress
// Configuration macro: MIPS_MULDIV_ALU_DIV_EN. When undefined, DIV/DIVU are
// handled like any undefined opcode (result = A) and no divider is built.
// ----------------------------------------------------------------------------
module mips_muldiv_alu
    import mips_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] first_data,
    input  logic [WIDTH-1:0] second_data,
    input  logic [SH_W-1:0]  shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int CNT_W = SH_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    state_e             state_q;
    state_e             state_d;

    logic               accept;
    logic               op_is_mul;
    logic               op_single;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH-1:0]   add_sum;
    logic [WIDTH-1:0]   sub_diff;

    logic               mul_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   mul_mcand;
    logic               mul_neg;
    logic [CNT_W-1:0]   mul_cnt;
    logic               mul_last;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] mul_final;

    assign accept    = in_valid && in_ready;
    assign op_is_mul = is_mul_op(alu_op);

`ifdef MIPS_MULDIV_ALU_DIV_EN
    logic             op_is_div;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    assign op_is_div = is_div_op(alu_op);
    assign op_single = !op_is_mul && !op_is_div;
    assign div_start = accept && op_is_div;

    mips_div_iter #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .is_signed (alu_op == OP_DIV),
        .dividend  (first_data),
        .divisor   (second_data),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`else
    assign op_single = !op_is_mul;
`endif

    // Single-cycle datapath. MFHI/MFLO read the registers directly, so an
    // MFHI/MFLO accepted in a completion cycle sees the freshly written value.
    always_comb begin
        add_sum  = first_data + second_data;
        sub_diff = first_data - second_data;
        alu_res  = first_data;
        alu_ovf  = 1'b0;
        case (alu_op)
            OP_AND:  alu_res = first_data & second_data;
            OP_OR:   alu_res = first_data | second_data;
            OP_NOR:  alu_res = ~(first_data | second_data);
            OP_XOR:  alu_res = first_data ^ second_data;
            OP_ADD: begin
                alu_res = add_sum;
                alu_ovf = (first_data[WIDTH-1] == second_data[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != first_data[WIDTH-1]);
            end
            OP_ADDU: alu_res = add_sum;
            OP_SUB: begin
                alu_res = sub_diff;
                alu_ovf = (first_data[WIDTH-1] != second_data[WIDTH-1]) &&
                          (sub_diff[WIDTH-1] != first_data[WIDTH-1]);
            end
            OP_SUBU: alu_res = sub_diff;
            OP_SLL:  alu_res = first_data << shamt;
            OP_SRL:  alu_res = first_data >> shamt;
            OP_SRA:  alu_res = $signed(first_data) >>> shamt;
            OP_LUI:  alu_res = {first_data[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                ($signed(first_data) < $signed(second_data))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (first_data < second_data)};
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = first_data;
        endcase
    end

    // Multiplier: operands are reduced to magnitudes at acceptance and the
    // product sign is reapplied in the completion cycle. Each step adds the
    // multiplicand into the upper half when the low multiplier bit is set,
    // then shifts the whole {carry, upper, multiplier} right by one.
    always_comb begin
        mul_signed = (alu_op == OP_MULT);
        a_neg      = mul_signed && first_data[WIDTH-1];
        b_neg      = mul_signed && second_data[WIDTH-1];
        a_mag      = a_neg ? -first_data  : first_data;
        b_mag      = b_neg ? -second_data : second_data;
        mul_sum    = {1'b0, mul_prod[2*WIDTH-1:WIDTH]} +
                     (mul_prod[0] ? {1'b0, mul_mcand} : '0);
        mul_next   = {mul_sum, mul_prod[WIDTH-1:1]};
        mul_final  = mul_neg ? -mul_prod : mul_prod;
        mul_last   = (mul_cnt == CNT_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave IDLE on an accepted iterative op and return in
    // the same edge that publishes the result, so the unit is ready again
    // while out_valid is high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && op_is_mul) begin
                    state_d = ST_MUL;
                end
`ifdef MIPS_MULDIV_ALU_DIV_EN
                else if (accept && op_is_div) begin
                    state_d = ST_DIV;
                end
`endif
            end
            ST_MUL: begin
                if (mul_last) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef MIPS_MULDIV_ALU_DIV_EN
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
    end

    // Result bundle, HI/LO and multiplier iteration registers. out_valid
    // defaults low so every completion is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            mul_prod  <= '0;
            mul_mcand <= '0;
            mul_neg   <= 1'b0;
            mul_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;

            if (accept && op_single) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                zero      <= (alu_res == '0);
                ovf       <= alu_ovf;
            end

            if (accept && op_is_mul) begin
                mul_prod  <= {{WIDTH{1'b0}}, b_mag};
                mul_mcand <= a_mag;
                mul_neg   <= a_neg ^ b_neg;
                mul_cnt   <= '0;
            end

            if (state_q == ST_MUL) begin
                if (!mul_last) begin
                    mul_prod <= mul_next;
                    mul_cnt  <= mul_cnt + CNT_W'(1);
                end else begin
                    hi        <= mul_final[2*WIDTH-1:WIDTH];
                    lo        <= mul_final[WIDTH-1:0];
                    result    <= mul_final[WIDTH-1:0];
                    zero      <= (mul_final[WIDTH-1:0] == '0);
                    ovf       <= 1'b0;
                    out_valid <= 1'b1;
                end
            end

`ifdef MIPS_MULDIV_ALU_DIV_EN
            if ((state_q == ST_DIV) && div_done) begin
                hi        <= div_rem;
                lo        <= div_quo;
                result    <= div_quo;
                zero      <= (div_quo == '0);
                ovf       <= 1'b0;
                out_valid <= 1'b1;
            end
`endif
        end
    end

endmodule
